// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state encoding and width helper for the SRAM port arbiter
package sram_arb_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_rr_pick.sv
// sram_rr_pick: combinational round-robin picker, first candidate at or after i_start
module sram_rr_pick import sram_arb_pkg::*; #(
  parameter int N = 2,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] i_valid,
  input  logic [W-1:0] i_start,
  input  logic [N-1:0] i_excl,
  output logic [W-1:0] o_idx,
  output logic         o_any
);
  logic [N-1:0] w_cand;
  assign w_cand = i_valid & ~i_excl;
  // scan from the farthest offset inward so the candidate nearest i_start wins
  always_comb begin
    logic [W-1:0] w_i;
    w_i   = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      w_i = W'((int'(i_start) + k) % N);
      if (w_cand[w_i]) begin
        o_idx = w_i;
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin burst arbiter sharing one single-port SRAM with registered drive
module sram_port_arbiter import sram_arb_pkg::*; #(
  parameter int NUM_REQ         = 2,
  parameter int SRAM_ADDR_WIDTH = 16,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int MAX_BURST       = 4
) (
  input  logic                                   sram_clk,
  input  logic                                   sram_rst_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*SRAM_ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*SRAM_DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*SRAM_DATA_WIDTH/8-1:0]   req_we,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  output logic [SRAM_DATA_WIDTH-1:0]             rsp_rdata,
  output logic [SRAM_ADDR_WIDTH-1:0]             sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0]             sram_din,
  output logic [SRAM_DATA_WIDTH/8-1:0]           sram_we,
  output logic                                   sram_en,
  input  logic [SRAM_DATA_WIDTH-1:0]             sram_dout
);
  localparam int REQ_IDX_W   = clog2_min1(NUM_REQ);
  localparam int BURST_CNT_W = clog2_min1(MAX_BURST);
  localparam int BW          = SRAM_DATA_WIDTH / 8;

  arb_state_e             r_state, w_state_nx;
  logic [REQ_IDX_W-1:0]   r_owner, r_rr_ptr, w_owner_nx, w_rr_ptr_nx, w_owner_inc, w_start, w_win;
  logic [BURST_CNT_W-1:0] r_burst_cnt, w_burst_cnt_nx;
  logic [NUM_REQ-1:0]     w_excl;
  logic                   w_any, w_fire, w_last, w_rel;
  logic [SRAM_ADDR_WIDTH-1:0] w_addr;
  logic [SRAM_DATA_WIDTH-1:0] w_wdata;
  logic [BW-1:0]          w_we;
  logic                   r_t1_v, r_t2_v;
  logic [REQ_IDX_W-1:0]   r_t1_tag, r_t2_tag;

  assign w_owner_inc = (int'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + 1'b1;
  assign w_fire      = (r_state == GRANT) && req_valid[r_owner];
  assign w_last      = w_fire && (int'(r_burst_cnt) == MAX_BURST - 1);
  assign w_rel       = (r_state == GRANT) && (!req_valid[r_owner] || w_last);
  assign w_start     = (r_state == GRANT) ? w_owner_inc : r_rr_ptr;
  assign w_excl      = w_last ? (NUM_REQ'(1) << r_owner) : '0;
  assign req_ready   = (r_state == GRANT) ? (NUM_REQ'(1) << r_owner) : '0;
  assign w_addr      = req_addr[int'(r_owner)*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
  assign w_wdata     = req_wdata[int'(r_owner)*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
  assign w_we        = req_we[int'(r_owner)*BW +: BW];
  assign rsp_valid   = r_t2_v ? (NUM_REQ'(1) << r_t2_tag) : '0;
  assign rsp_rdata   = sram_dout;

  sram_rr_pick #(.N(NUM_REQ), .W(REQ_IDX_W)) u_pick (
    .i_valid(req_valid),
    .i_start(w_start),
    .i_excl (w_excl),
    .o_idx  (w_win),
    .o_any  (w_any)
  );

  // arbitration: idle pick, burst counting, and zero-bubble handover on release
  always_comb begin
    w_state_nx     = r_state;
    w_owner_nx     = r_owner;
    w_rr_ptr_nx    = r_rr_ptr;
    w_burst_cnt_nx = r_burst_cnt;
    if (r_state == IDLE) begin
      w_state_nx     = w_any ? GRANT : IDLE;
      w_owner_nx     = w_any ? w_win : r_owner;
      w_burst_cnt_nx = w_any ? '0 : r_burst_cnt;
    end else if (w_rel) begin
      w_rr_ptr_nx    = w_owner_inc;
      w_state_nx     = w_any ? GRANT : IDLE;
      w_owner_nx     = w_any ? w_win : r_owner;
      w_burst_cnt_nx = '0;
    end else if (w_fire) begin
      w_burst_cnt_nx = r_burst_cnt + 1'b1;
    end
  end

  // arbitration state registers
  always_ff @(posedge sram_clk or negedge sram_rst_n) begin
    if (!sram_rst_n) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_owner     <= w_owner_nx;
      r_rr_ptr    <= w_rr_ptr_nx;
      r_burst_cnt <= w_burst_cnt_nx;
    end
  end

  // registered SRAM drive plus read-tag pipe aligned to the SRAM's one-cycle read
  always_ff @(posedge sram_clk or negedge sram_rst_n) begin
    if (!sram_rst_n) begin
      sram_en   <= 1'b0;
      sram_we   <= '0;
      sram_addr <= '0;
      sram_din  <= '0;
      r_t1_v    <= 1'b0;
      r_t2_v    <= 1'b0;
      r_t1_tag  <= '0;
      r_t2_tag  <= '0;
    end else begin
      sram_en   <= w_fire;
      sram_we   <= w_fire ? w_we : '0;
      sram_addr <= w_fire ? w_addr : sram_addr;
      sram_din  <= w_fire ? w_wdata : sram_din;
      r_t1_v    <= w_fire && (w_we == '0);
      r_t1_tag  <= r_owner;
      r_t2_v    <= r_t1_v;
      r_t2_tag  <= r_t1_tag;
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: table, directed and random checks against a behavioural arbiter/SRAM model
module tb_sram_port_arbiter;
  localparam int N = 2, AW = 16, DW = 32, BW = 4, MB = 4;

  logic sram_clk = 1'b0, sram_rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*BW-1:0] req_we;
  logic [DW-1:0] rsp_rdata, sram_din, sram_dout;
  logic [AW-1:0] sram_addr;
  logic [BW-1:0] sram_we;
  logic sram_en;

  bit [DW-1:0] smem [256];
  bit [DW-1:0] rmem [256];
  int n_vec = 0, n_bad = 0, cyc = 0;

  typedef struct {int due; int tag; logic [DW-1:0] data;} rsp_t;
  rsp_t q[$];
  typedef struct {logic [N-1:0] v; logic [N-1:0] rdy;} tv_t;

  bit m_gnt;
  int m_own, m_ptr, m_cnt;
  logic e_en;
  logic [BW-1:0] e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  logic [N-1:0] last_fire;

  always #5 sram_clk = ~sram_clk;

  sram_port_arbiter #(.NUM_REQ(N), .SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .sram_clk(sram_clk), .sram_rst_n(sram_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_we(sram_we), .sram_en(sram_en),
    .sram_dout(sram_dout)
  );

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d, logic [BW-1:0] we);
    merge = old;
    for (int b = 0; b < BW; b++) if (we[b]) merge[8*b +: 8] = d[8*b +: 8];
  endfunction

  // single-port synchronous SRAM seen by the DUT
  always @(posedge sram_clk) begin
    if (sram_en && sram_we == '0) sram_dout <= smem[sram_addr[7:0]];
    if (sram_en && sram_we != '0) smem[sram_addr[7:0]] <= merge(smem[sram_addr[7:0]], sram_din, sram_we);
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int start, int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (v[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic set_req(int i, logic v, logic [AW-1:0] a, logic [DW-1:0] d, logic [BW-1:0] w);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_we[i*BW +: BW] = w;
  endtask

  task automatic m_reset();
    m_gnt = 0; m_own = 0; m_ptr = 0; m_cnt = 0;
    e_en = 0; e_we = '0; e_addr = '0; e_din = '0;
    last_fire = '0;
    q.delete();
  endtask

  task automatic step();
    logic [N-1:0] er, v;
    bit fire, last;
    int w, o;
    v = req_valid;
    er = m_gnt ? (N'(1) << m_own) : '0;
    chk("req_ready", req_ready, er);
    o = m_own;
    fire = m_gnt && v[o];
    last_fire = fire ? er : '0;
    if (fire) begin
      e_en = 1; e_addr = req_addr[o*AW +: AW]; e_din = req_wdata[o*DW +: DW]; e_we = req_we[o*BW +: BW];
      if (e_we == '0) q.push_back('{cyc + 2, o, rmem[e_addr[7:0]]});
      else rmem[e_addr[7:0]] = merge(rmem[e_addr[7:0]], e_din, e_we);
    end else begin
      e_en = 0; e_we = '0;
    end
    if (!m_gnt) begin
      w = pick(v, m_ptr, -1);
      if (w >= 0) begin m_gnt = 1; m_own = w; m_cnt = 0; end
    end else begin
      last = fire && m_cnt == MB - 1;
      if (!v[o] || last) begin
        m_ptr = (o + 1) % N;
        w = pick(v, m_ptr, last ? o : -1);
        if (w >= 0) begin m_own = w; m_cnt = 0; end else m_gnt = 0;
      end else if (fire) m_cnt++;
    end
    @(posedge sram_clk); #1; cyc++;
    chk("sram_en", sram_en, e_en);
    chk("sram_we", sram_we, e_we);
    chk("sram_addr", sram_addr, e_addr);
    chk("sram_din", sram_din, e_din);
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_valid", rsp_valid, N'(1) << q[0].tag);
      chk("rsp_rdata", rsp_rdata, q[0].data);
      void'(q.pop_front());
    end else chk("rsp_valid", rsp_valid, '0);
  endtask

  task automatic xfer(int i, logic [AW-1:0] a, logic [DW-1:0] d, logic [BW-1:0] w);
    bit done = 0;
    set_req(i, 1'b1, a, d, w);
    for (int k = 0; k < 20 && !done; k++) begin
      done = m_gnt && m_own == i;
      step();
    end
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL xfer_timeout: requester %0d got no grant in 20 cycles, expected a grant", i);
    end
  endtask

  task automatic idle(int n);
    req_valid = '0;
    repeat (n) step();
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_ready"}, req_ready, '0);
    chk({nm, "_rsp_valid"}, rsp_valid, '0);
    chk({nm, "_sram_en"}, sram_en, '0);
    chk({nm, "_sram_we"}, sram_we, '0);
    chk({nm, "_sram_addr"}, sram_addr, '0);
    chk({nm, "_sram_din"}, sram_din, '0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    sram_rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge sram_clk);
    #1;
    chk_zero("reset");
    sram_rst_n = 1'b1;
  endtask

  initial begin
    tv_t tv[15];
    req_valid = '0; req_addr = '0; req_wdata = '0; req_we = '0;
    tv = '{'{2'b11, 2'b00}, '{2'b11, 2'b01}, '{2'b11, 2'b01}, '{2'b11, 2'b01}, '{2'b11, 2'b01},
           '{2'b11, 2'b10}, '{2'b11, 2'b10}, '{2'b11, 2'b10}, '{2'b11, 2'b10},
           '{2'b11, 2'b01}, '{2'b11, 2'b01}, '{2'b11, 2'b01}, '{2'b11, 2'b01},
           '{2'b00, 2'b10}, '{2'b00, 2'b00}};
    do_reset();

    xfer(0, 16'h0010, 32'hDEADBEEF, 4'hF);
    chk("single_we", sram_we, 4'hF);
    chk("single_en", sram_en, 1'b1);
    xfer(0, 16'h0010, '0, '0);
    set_req(0, 1'b0, 16'h0010, '0, '0);
    step();
    chk("single_rsp_v", rsp_valid, 2'b01);
    chk("single_rsp_d", rsp_rdata, 32'hDEADBEEF);
    idle(3);

    xfer(0, 16'h0030, 32'h11223344, 4'hF);
    xfer(0, 16'h0030, 32'h000000AA, 4'b0001);
    xfer(0, 16'h0030, '0, '0);
    set_req(0, 1'b0, 16'h0030, '0, '0);
    step();
    chk("byte_rsp_v", rsp_valid, 2'b01);
    chk("byte_rsp_d", rsp_rdata, 32'h112233AA);
    idle(3);

    xfer(1, 16'h0040, 32'h40404040, 4'hF);
    xfer(1, 16'h0041, 32'h41414141, 4'hF);
    set_req(1, 1'b0, 16'h0041, '0, '0);
    set_req(0, 1'b1, 16'h0042, 32'h42424242, 4'hF);
    step();
    chk("early_ready", req_ready, 2'b01);
    chk("early_rr_ptr", dut.r_rr_ptr, 0);
    step();
    idle(3);

    xfer(0, 16'h0001, 32'h11110001, 4'hF);
    xfer(0, 16'h0002, 32'h22220002, 4'hF);
    xfer(0, 16'h0003, 32'h33330003, 4'hF);
    set_req(1, 1'b1, 16'h0002, '0, '0);
    xfer(0, 16'h0001, '0, '0);
    set_req(0, 1'b0, 16'h0001, '0, '0);
    chk("il_handover", req_ready, 2'b10);
    step();
    chk("il_rsp0_v", rsp_valid, 2'b01);
    chk("il_rsp0_d", rsp_rdata, 32'h11110001);
    set_req(1, 1'b0, 16'h0002, '0, '0);
    step();
    chk("il_rsp1_v", rsp_valid, 2'b10);
    chk("il_rsp1_d", rsp_rdata, 32'h22220002);
    idle(3);

    do_reset();
    set_req(0, 1'b0, 16'h0020, 32'hC0FFEE00, 4'hF);
    set_req(1, 1'b0, 16'h0020, '0, '0);
    for (int k = 0; k < 15; k++) begin
      req_valid = tv[k].v;
      chk("tbl_ready", req_ready, tv[k].rdy);
      step();
    end

    idle(2);
    xfer(0, 16'h0010, '0, '0);
    req_valid = '0;
    sram_rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    m_reset();
    repeat (3) step();
    sram_rst_n = 1'b1;
    step();
    set_req(0, 1'b1, 16'h0010, '0, '0);
    chk("post_rst_bubble", req_ready, 2'b00);
    step();
    chk("post_rst_grant", req_ready, 2'b01);

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_fire[i] || !(m_gnt && m_own == i))
          set_req(i, $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom_range(1, 15)));
        else req_valid[i] = $urandom_range(0, 3) != 0;
      end
      step();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM between `NUM_REQ` requesters in the `sram_clk` domain, such as the AXI-side `sram_controller` path and a DMA or scrub engine. It grants the port round-robin, lets the granted requester issue back-to-back bursts up to `MAX_BURST` beats, and registers all SRAM control signals. It routes one-cycle-latency read data back to the requester that issued the read.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2–4).
- `SRAM_ADDR_WIDTH`, 16: SRAM word address width.
- `SRAM_DATA_WIDTH`, 32: SRAM data width, a multiple of 8.
- `MAX_BURST`, 4: maximum beats accepted per grant before rotation (≥1).

Ports:
- `sram_clk` in 1: single clock for the whole block.
- `sram_rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester access request.
- `req_ready` out `NUM_REQ`: per-requester accept; a beat transfers when `valid && ready`.
- `req_addr` in `NUM_REQ*SRAM_ADDR_WIDTH`: flattened; requester i uses slice i.
- `req_wdata` in `NUM_REQ*SRAM_DATA_WIDTH`: flattened write data.
- `req_we` in `NUM_REQ*SRAM_DATA_WIDTH/8`: flattened byte enables; all-zero means read.
- `rsp_valid` out `NUM_REQ`: one-hot read-data strobe.
- `rsp_rdata` out `SRAM_DATA_WIDTH`: shared read data, qualified by `rsp_valid`.
- `sram_addr` out `SRAM_ADDR_WIDTH`, `sram_din` out `SRAM_DATA_WIDTH`, `sram_we` out `SRAM_DATA_WIDTH/8`, `sram_en` out 1: registered SRAM drive.
- `sram_dout` in `SRAM_DATA_WIDTH`: valid one cycle after a read-enable cycle.

## Operation
- **States:** `IDLE` and `GRANT`. The block holds registers `owner` (index), `rr_ptr` (next-priority index) and `burst_cnt` (0..`MAX_BURST-1`).
- **IDLE:**
  - All `req_ready` are 0.
  - If any `req_valid` is high, pick the first valid requester starting from `rr_ptr` and wrapping modulo `NUM_REQ`.
  - On a pick: `owner <= winner`, `burst_cnt <= 0`, go to `GRANT`.
- **GRANT:**
  - `req_ready[owner] = 1`; all other `req_ready` are 0. Ready depends only on registered state.
  - An accepted beat increments `burst_cnt`.
- **Release:** the grant is released when `req_valid[owner]` is low, or when a beat is accepted with `burst_cnt == MAX_BURST-1`. On release:
  - `rr_ptr <= owner+1` (mod `NUM_REQ`).
  - If any other requester is valid, pick from `owner+1` round-robin, load it into `owner`, clear `burst_cnt` and stay in `GRANT`. The release test and the re-pick use the same cycle's valids.
  - Otherwise go to `IDLE`.
  - The current owner is excluded from the re-pick only when it was released by burst exhaustion.
- **SRAM drive:**
  - For a beat accepted in cycle T, in T+1: `sram_en=1`, `sram_addr`/`sram_din` are the beat's address/data, `sram_we` is the beat's byte enables.
  - With no beat in T: `sram_en=0`, `sram_we=0`, and addr/din hold their previous values.
- **Read return:**
  - A read beat (`we == 0`) carries its owner index through a 2-stage tag pipe.
  - In T+2: `rsp_valid[tag]=1` and `rsp_rdata = sram_dout`, driven combinationally from `sram_dout`.
  - Writes produce no response.
- **Reset values:**
  - `req_ready=0`, `rsp_valid=0`, `sram_en=0`, `sram_we=0`, `sram_addr=0`, `sram_din=0`.
  - `owner=0`, `rr_ptr=0`, `burst_cnt=0`, state `IDLE`.
- **Reset mid-operation:** in-flight reads are dropped with no `rsp_valid`, and no SRAM write is issued after reset asserts.
- There is no backpressure on responses; requesters must always sink `rsp_valid`.

## Timing
- Arbitration bubble: 1 cycle from the first `req_valid` in `IDLE` to `req_ready`.
- Owner handover in `GRANT`: 0 bubble cycles.
- Throughput: 1 beat per cycle while granted.
- Read latency: accept at T, `sram_en` at T+1, `rsp_valid` at T+2.
- Write latency: accept at T, SRAM write at T+1.
- Read-after-write to the same address from any requesters in consecutive beats returns the new data, because the SRAM is in-order.
- A requester may change `addr`/`wdata`/`we` only after a transfer or while `req_ready` is 0; valid may drop at any time.

## Structure
- **Package `sram_arb_pkg`:** state enum `arb_state_e {IDLE, GRANT}` as `logic [0:0]`, plus localparams `REQ_IDX_W = $clog2(NUM_REQ)` and `BURST_CNT_W = $clog2(MAX_BURST)` (minimum 1).
- **Sub-module `sram_rr_pick`:** combinational round-robin picker. Inputs are the valid vector, start pointer and exclude mask; outputs are winner index and `any`. It is instantiated once and shared by the `IDLE` and release paths.

## Test plan
- **Single requester:** req 0 issues write addr 0x0010, data 0xDEADBEEF, we 4'hF, then a read of 0x0010. Expect `sram_we=F` one cycle after accept, then `rsp_valid[0]` with `rsp_rdata` 0xDEADBEEF two cycles after the read accept.
- **Simultaneous requests from reset:** both requesters hold valid for 12 beats with `MAX_BURST=4`. Expect grant order 0,0,0,0,1,1,1,1,0…, no idle cycle at handovers, and no `req_ready` overlap.
- **Byte write:** write 0x11223344, then a write of 0x000000AA with we 4'b0001 to the same address, then a read. Expect 0x112233AA.
- **Early release:** req 1 drops valid after 2 of 4 beats while req 0 is valid. Expect ownership to pass to req 0 the next cycle and `rr_ptr` to become 0.
- **Interleaved reads:** req 0 reads 0x0001 and req 1 reads 0x0002 back-to-back. Expect `rsp_valid` of `01` then `10` with matching data tags.
- **Reset mid-read:** assert `sram_rst_n` low the cycle after a read accept. Expect no `rsp_valid`, all outputs zero, and state `IDLE` after release.
